// File: rtl/fu_operand_issuer_pkg.sv
// Shared opcode type for the PE issue path and the functional unit.
// Opcodes are grouped by how the issuer sequences them.
package fu_operand_issuer_pkg;

  typedef enum logic [3:0] {
    FU_ADD,
    FU_SUB,
    FU_AND,
    FU_XOR,
    FU_MUL,
    FU_DIV,
    FU_DIVU,
    FU_REM,
    FU_ADDPOW,
    FU_ACC,
    FU_MAX
  } fu_instr_t;

endpackage

// File: rtl/fu_operand_issuer_if.sv
// PE-side bundle: operand streams in, FU operand/result handshake,
// and the registered result stream out.
interface fu_operand_issuer_if
  import fu_operand_issuer_pkg::*;
#(
  parameter int N_BITS = 32,
  parameter int CNT_W  = 8
);

  fu_instr_t          instr;
  logic [CNT_W-1:0]   acc_len;
  logic [N_BITS-1:0]  a;
  logic               a_valid;
  logic               a_ready;
  logic [N_BITS-1:0]  b;
  logic               b_valid;
  logic               b_ready;
  fu_instr_t          fu_instr;
  logic [N_BITS-1:0]  fu_a;
  logic [N_BITS-1:0]  fu_b;
  logic               fu_ops_valid;
  logic               fu_ready;
  logic               fu_valid;
  logic [N_BITS-1:0]  fu_res;
  logic [N_BITS-1:0]  out;
  logic               out_valid;
  logic               out_ready;

  modport master (
    input  instr, acc_len,
    input  a, a_valid, b, b_valid,
    input  fu_ready, fu_valid, fu_res,
    input  out_ready,
    output a_ready, b_ready,
    output fu_instr, fu_a, fu_b, fu_ops_valid,
    output out, out_valid
  );

  modport slave (
    output instr, acc_len,
    output a, a_valid, b, b_valid,
    output fu_ready, fu_valid, fu_res,
    output out_ready,
    input  a_ready, b_ready,
    input  fu_instr, fu_a, fu_b, fu_ops_valid,
    input  out, out_valid
  );

endinterface

// File: rtl/fu_operand_issuer.sv
// Issue controller in front of the FU: single-cycle pass-through,
// multi-cycle issue/wait, and ACC/MAX reductions looped on operand A.
module fu_operand_issuer
  import fu_operand_issuer_pkg::*;
#(
  parameter int N_BITS = 32,
  parameter int CNT_W  = 8
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  fu_operand_issuer_if.master io
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RED
  } state_e;

  state_e            state_q, state_d;
  fu_instr_t         instr_q, op;
  logic [N_BITS-1:0] acc_q, fa_q, fb_q, out_q;
  logic [N_BITS-1:0] fa_d, fb_d;
  logic [CNT_W-1:0]  cnt_q, cnt_nx, len;
  logic              out_vq, out_free, last;
  logic              is_multi, is_red;
  logic              a_rdy, b_rdy, ops_v, ld;

  assign op       = (state_q == S_IDLE) ? io.instr : instr_q;
  assign is_multi = op inside {FU_DIV, FU_DIVU, FU_REM, FU_ADDPOW};
  assign is_red   = op inside {FU_ACC, FU_MAX};
  assign out_free = !out_vq | io.out_ready;
  assign len      = (io.acc_len == '0) ? CNT_W'(1) : io.acc_len;
  assign cnt_nx   = cnt_q + 1'b1;
  assign last     = (cnt_nx == len);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (is_red) begin
          if (io.b_valid && out_free) state_d = S_RED;
        end else if (is_multi) begin
          if (io.a_valid && io.b_valid && !out_vq)
            state_d = S_ISSUE;
        end
      end
      S_ISSUE: if (io.fu_ready) state_d = S_WAIT;
      S_WAIT:  if (io.fu_valid) state_d = S_IDLE;
      S_RED:   if (ops_v && last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    a_rdy = 1'b0;
    b_rdy = 1'b0;
    ops_v = 1'b0;
    fa_d  = fa_q;
    fb_d  = fb_q;
    unique case (state_q)
      S_IDLE: begin
        if (!is_red && !is_multi && io.a_valid
            && io.b_valid && out_free) begin
          ops_v = 1'b1;
          a_rdy = 1'b1;
          b_rdy = 1'b1;
          fa_d  = io.a;
          fb_d  = io.b;
        end
      end
      S_ISSUE: begin
        ops_v = 1'b1;
        fa_d  = io.a;
        fb_d  = io.b;
        a_rdy = io.fu_ready;
        b_rdy = io.fu_ready;
      end
      S_WAIT: ;
      S_RED: begin
        // the last sample may only go once the result slot can take it
        if (io.b_valid && (!last || out_free)) begin
          ops_v = 1'b1;
          b_rdy = 1'b1;
          fb_d  = io.b;
          if (cnt_q != '0)            fa_d = acc_q;
          else if (instr_q == FU_MAX) fa_d = io.b;
          else                        fa_d = '0;
        end
      end
      default: ;
    endcase
  end

  assign ld = (state_q == S_IDLE && ops_v)
           || (state_q == S_WAIT && io.fu_valid)
           || (state_q == S_RED && ops_v && last);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      instr_q <= FU_ADD;
      acc_q   <= '0;
      cnt_q   <= '0;
      fa_q    <= '0;
      fb_q    <= '0;
      out_q   <= '0;
      out_vq  <= 1'b0;
    end else begin
      if (state_q == S_IDLE && state_d != S_IDLE) begin
        instr_q <= io.instr;
        acc_q   <= '0;
        cnt_q   <= '0;
      end
      if (b_rdy) begin
        fa_q <= fa_d;
        fb_q <= fb_d;
      end
      if (state_q == S_RED && ops_v) begin
        if (last) begin
          acc_q <= '0;
          cnt_q <= '0;
        end else begin
          acc_q <= io.fu_res;
          cnt_q <= cnt_nx;
        end
      end
      if (ld) begin
        out_q  <= io.fu_res;
        out_vq <= 1'b1;
      end else if (io.out_ready) begin
        out_vq <= 1'b0;
      end
    end
  end

  assign io.a_ready      = a_rdy;
  assign io.b_ready      = b_rdy;
  assign io.fu_ops_valid = ops_v;
  assign io.fu_a         = fa_d;
  assign io.fu_b         = fb_d;
  assign io.fu_instr     = op;
  assign io.out          = out_q;
  assign io.out_valid    = out_vq;

endmodule

// File: tb/tb_fu_operand_issuer.sv
// Scoreboard bench: random jobs against a job-level result model,
// with a behavioural FU and decoupled output monitor.
module tb_fu_operand_issuer;
  import fu_operand_issuer_pkg::*;

  localparam int NB = 32;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fu_operand_issuer_if #(.N_BITS(NB), .CNT_W(CW)) bus ();

  fu_operand_issuer #(.N_BITS(NB), .CNT_W(CW)) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .io     (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [NB-1:0] qa[$], qb[$], sbq[$], fa_log[$];
  int or_mode   = 0;
  bit rnd_valid = 1'b1;
  int force_lat = 0;
  bit fu_busy   = 1'b0;
  int fu_lat    = 0;
  logic [NB-1:0] pend = '0;
  int red_a_viol = 0;
  int wait_viol  = 0;

  function automatic logic [NB-1:0] fu_op(fu_instr_t o,
                                          logic [NB-1:0] a,
                                          logic [NB-1:0] b);
    case (o)
      FU_ADD:    return a + b;
      FU_SUB:    return a - b;
      FU_AND:    return a & b;
      FU_XOR:    return a ^ b;
      FU_MUL:    return a * b;
      FU_DIV:    return (b == 0) ? '1 : NB'($signed(a) / $signed(b));
      FU_DIVU:   return (b == 0) ? '1 : a / b;
      FU_REM:    return (b == 0) ? a : NB'($signed(a) % $signed(b));
      FU_ADDPOW: return a + b * b;
      FU_ACC:    return a + b;
      FU_MAX:    return ($signed(a) > $signed(b)) ? a : b;
      default:   return '0;
    endcase
  endfunction

  function automatic bit is_multi_op(fu_instr_t o);
    return o inside {FU_DIV, FU_DIVU, FU_REM, FU_ADDPOW};
  endfunction

  always @* bus.fu_res = bus.fu_valid ? pend
                       : fu_op(bus.fu_instr, bus.fu_a, bus.fu_b);

  task automatic chk(string nm, logic [NB-1:0] act, logic [NB-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic finish_run();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  endtask

  task automatic timeout(string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got timeout expected event", nm);
    finish_run();
  endtask

  // source/sink drivers, FU model and output monitor
  initial begin
    bit a_x, b_x, o_x, fu_acc;
    logic [NB-1:0] acc_res;
    bus.a = '0; bus.a_valid = 1'b0;
    bus.b = '0; bus.b_valid = 1'b0;
    bus.fu_ready = 1'b0; bus.fu_valid = 1'b0;
    bus.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      a_x = bus.a_valid & bus.a_ready;
      b_x = bus.b_valid & bus.b_ready;
      o_x = bus.out_valid & bus.out_ready;
      fu_acc = bus.fu_ops_valid & bus.fu_ready & is_multi_op(bus.fu_instr);
      acc_res = bus.fu_res;
      if (o_x) begin
        if (sbq.size() == 0) chk("unexpected_out", bus.out, 'x);
        else chk("result", bus.out, sbq.pop_front());
      end
      if (bus.a_ready && bus.fu_instr inside {FU_ACC, FU_MAX})
        red_a_viol++;
      if (fu_busy && (bus.fu_ops_valid | bus.a_ready | bus.b_ready))
        wait_viol++;
      if (bus.fu_ops_valid && bus.b_ready
          && bus.fu_instr inside {FU_ACC, FU_MAX})
        fa_log.push_back(bus.fu_a);
      @(posedge clk);
      #1;
      if (a_x && qa.size() > 0) void'(qa.pop_front());
      if (b_x && qb.size() > 0) void'(qb.pop_front());
      if (qa.size() == 0) bus.a_valid = 1'b0;
      else if (!(bus.a_valid && !a_x))
        bus.a_valid = !rnd_valid || ($urandom % 4 != 0);
      bus.a = (qa.size() > 0) ? qa[0] : '0;
      if (qb.size() == 0) bus.b_valid = 1'b0;
      else if (!(bus.b_valid && !b_x))
        bus.b_valid = !rnd_valid || ($urandom % 4 != 0);
      bus.b = (qb.size() > 0) ? qb[0] : '0;
      if (bus.fu_valid) begin
        bus.fu_valid = 1'b0;
        fu_busy = 1'b0;
      end else if (fu_acc) begin
        fu_busy = 1'b1;
        pend = acc_res;
        fu_lat = (force_lat > 0) ? force_lat : int'($urandom_range(1, 6));
      end else if (fu_busy) begin
        fu_lat--;
        if (fu_lat <= 0) bus.fu_valid = 1'b1;
      end
      bus.fu_ready = !fu_busy && ($urandom % 3 != 0);
      case (or_mode)
        1:       bus.out_ready = 1'b0;
        2:       bus.out_ready = 1'b1;
        default: bus.out_ready = ($urandom % 4 != 0);
      endcase
    end
  end

  task automatic wait_idle();
    int t = 0;
    while ((sbq.size() != 0 || qa.size() != 0 || qb.size() != 0
            || fu_busy) && t < 3000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 3000) timeout("drain");
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic pair(logic [NB-1:0] a, logic [NB-1:0] b);
    qa.push_back(a);
    qb.push_back(b);
    sbq.push_back(fu_op(bus.instr, a, b));
  endtask

  task automatic red_job(fu_instr_t o, int len, logic [NB-1:0] v[$]);
    logic [NB-1:0] r;
    bus.instr = o;
    bus.acc_len = CW'(len);
    r = (o == FU_MAX) ? v[0] : '0;
    foreach (v[i]) begin
      if (o == FU_ACC) r = r + v[i];
      else if ($signed(v[i]) > $signed(r)) r = v[i];
      qb.push_back(v[i]);
    end
    sbq.push_back(r);
  endtask

  initial begin
    fu_instr_t singles[5] = '{FU_ADD, FU_SUB, FU_AND, FU_XOR, FU_MUL};
    fu_instr_t multis[4] = '{FU_DIV, FU_DIVU, FU_REM, FU_ADDPOW};
    logic [NB-1:0] acc_exp[4] = '{32'd0, 32'd1, 32'd3, 32'd6};
    logic [NB-1:0] v[$];
    logic [NB-1:0] held;
    int t;
    bus.instr = FU_ADD;
    bus.acc_len = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_out", bus.out, '0);
    chk("rst_out_valid", NB'(bus.out_valid), '0);
    chk("rst_a_ready", NB'(bus.a_ready), '0);
    chk("rst_b_ready", NB'(bus.b_ready), '0);
    chk("rst_ops_valid", NB'(bus.fu_ops_valid), '0);
    rst_n = 1'b1;
    @(posedge clk);
    #2;

    rnd_valid = 1'b0;
    or_mode = 2;
    bus.instr = FU_ADD;
    pair(32'd3, 32'd4);
    pair(32'd10, 32'd20);
    pair(32'd5, 32'hFFFF_FFFF);
    wait_idle();

    bus.instr = FU_DIV;
    pair(32'd100, 32'd7);
    wait_idle();

    rnd_valid = 1'b1;
    fa_log.delete();
    v = '{32'd1, 32'd2, 32'd3, 32'd4};
    red_job(FU_ACC, 4, v);
    wait_idle();
    chk("acc_samples", NB'(fa_log.size()), NB'(4));
    for (int i = 0; i < 4; i++)
      if (i < fa_log.size()) chk("acc_fu_a", fa_log[i], acc_exp[i]);

    fa_log.delete();
    v = '{-32'sd5, 32'd2, -32'sd1};
    red_job(FU_MAX, 3, v);
    wait_idle();
    chk("max_first_fu_a", (fa_log.size() > 0) ? fa_log[0] : 'x, -32'sd5);
    v = '{32'd9};
    red_job(FU_MAX, 0, v);
    wait_idle();

    rnd_valid = 1'b0;
    or_mode = 1;
    bus.instr = FU_ADD;
    pair(32'd1, 32'd2);
    t = 0;
    while (!bus.out_valid && t < 50) begin
      @(posedge clk);
      t++;
    end
    if (t >= 50) timeout("bp_first");
    #2;
    held = bus.out;
    pair(32'd7, 32'd8);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("bp_a_ready", NB'(bus.a_ready), '0);
    chk("bp_out_held", bus.out, held);
    or_mode = 2;
    @(posedge clk);
    @(negedge clk);
    chk("bp_release_issue", NB'(bus.a_ready & bus.fu_ops_valid), NB'(1));
    wait_idle();

    force_lat = 30;
    bus.instr = FU_DIV;
    pair(32'd100, 32'd7);
    t = 0;
    while (!fu_busy && t < 100) begin
      @(posedge clk);
      t++;
    end
    if (t >= 100) timeout("div_accept");
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_out", bus.out, '0);
    chk("arst_out_valid", NB'(bus.out_valid), '0);
    chk("arst_a_ready", NB'(bus.a_ready), '0);
    chk("arst_ops_valid", NB'(bus.fu_ops_valid), '0);
    sbq.delete();
    qa.delete();
    qb.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    wait_idle();
    chk("late_fu_valid_ignored", NB'(bus.out_valid), '0);
    force_lat = 0;
    bus.instr = FU_ADD;
    pair(32'd3, 32'd4);
    wait_idle();

    rnd_valid = 1'b1;
    or_mode = 0;
    for (int j = 0; j < 40; j++) begin
      int k;
      k = int'($urandom % 3);
      if (k == 0) begin
        bus.instr = singles[$urandom % 5];
        for (int i = int'($urandom_range(1, 6)); i > 0; i--)
          pair($urandom, $urandom);
      end else if (k == 1) begin
        bus.instr = multis[$urandom % 4];
        for (int i = int'($urandom_range(1, 3)); i > 0; i--)
          pair($urandom, ($urandom % 2) ? NB'($urandom_range(1, 999))
                                        : -NB'($urandom_range(1, 999)));
      end else begin
        int len, ns;
        len = int'($urandom_range(0, 6));
        ns = (len == 0) ? 1 : len;
        v.delete();
        for (int i = 0; i < ns; i++) v.push_back($urandom);
        red_job(($urandom % 2) ? FU_MAX : FU_ACC, len, v);
      end
      wait_idle();
    end

    chk("red_a_ready_low", NB'(red_a_viol), '0);
    chk("wait_quiet", NB'(wait_viol), '0);
    chk("scoreboard_empty", NB'(sbq.size()), '0);
    finish_run();
  end

endmodule
